hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage core (F, D, E, M, W). It drives the `en` input (as `~stallX`) and the `flush` input of every inter-stage pipeline register. It also drives the forwarding-mux selects. It sequences multi-cycle divide stalls and exception flushes with an internal FSM and counter. It sits beside the datapath and consumes register addresses and control bits from the D, E, M and W stages.

---
 rtl/hazard_if.sv | 39 +++
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Hazard controller port bundle: datapath stage fields in,
// stall/flush/forwarding controls out.
interface hazard_if;
  logic [4:0]  rsD, rtD, rsE, rtE;
  logic [4:0]  writeregE, writeregM, writeregW;
  logic        regwriteE, regwriteM, regwriteW;
  logic        memtoregE, memtoregM;
  logic        branchD, divE, excM;
  logic        stallF, stallD, stallE, stallM, stallW;
  logic        flushD, flushE, flushM, flushW;
  logic        forwardAD, forwardBD;
  logic [1:0]  forwardAE, forwardBE;
  logic        div_busy, div_doneE;
  logic [31:0] stall_cnt;

  modport slave (
    input  rsD, rtD, rsE, rtE,
    input  writeregE, writeregM, writeregW,
    input  regwriteE, regwriteM, regwriteW,
    input  memtoregE, memtoregM,
    input  branchD, divE, excM,
    output stallF, stallD, stallE, stallM, stallW,
    output flushD, flushE, flushM, flushW,
    output forwardAD, forwardBD, forwardAE, forwardBE,
    output div_busy, div_doneE, stall_cnt
  );

  modport master (
    output rsD, rtD, rsE, rtE,
    output writeregE, writeregM, writeregW,
    output regwriteE, regwriteM, regwriteW,
    output memtoregE, memtoregM,
    output branchD, divE, excM,
    input  stallF, stallD, stallE, stallM, stallW,
    input  flushD, flushE, flushM, flushW,
    input  forwardAD, forwardBD, forwardAE, forwardBE,
    input  div_busy, div_doneE, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard/stall controller: load-use, branch,
// forwarding, multi-cycle divide sequencing and exception flush.
module hazard_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input logic clk,
  input logic rst,
  hazard_if.slave hz
);
  localparam int CW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   scnt;
  logic          div_st, lu, br, hz_st, stall_d;

  function automatic logic [1:0] fwd_e(
    input logic [4:0] s,
    input logic       wm,
    input logic [4:0] rm,
    input logic       ww,
    input logic [4:0] rw
  );
    logic hm, hw;
    hm = (s != 5'd0) && wm && (rm == s);
    hw = (s != 5'd0) && ww && (rw == s);
    fwd_e = 2'b00;
    priority case (1'b1)
      hm:      fwd_e = 2'b10;
      hw:      fwd_e = 2'b01;
      default: fwd_e = 2'b00;
    endcase
  endfunction

  function automatic logic br_hit(input logic [4:0] s);
    br_hit = (s != 5'd0) &&
      ((hz.regwriteE && hz.writeregE == s) ||
       (hz.memtoregM && hz.writeregM == s));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      scnt  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (stall_d) scnt <= scnt + 32'd1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: if (hz.divE && !hz.excM) begin
        state_n = DIV;
        cnt_n   = CW'(DIV_CYCLES - 2);
      end
      DIV: begin
        if (cnt == '0) state_n = DONE;
        else cnt_n = cnt - CW'(1);
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (hz.excM) state_n = IDLE;
  end

  // IDLE+divE stalls immediately so the total stall is DIV_CYCLES
  always_comb begin
    div_st = (state == DIV) ||
             (state == IDLE && hz.divE);
    lu = (state != DIV) && hz.memtoregE &&
         (hz.rtE != 5'd0) &&
         (hz.rtE == hz.rsD || hz.rtE == hz.rtD);
    br = (state != DIV) && hz.branchD &&
         (br_hit(hz.rsD) || br_hit(hz.rtD));
    hz_st   = lu || br;
    stall_d = !hz.excM && (div_st || hz_st);
  end

  always_comb begin
    hz.stallF    = 1'b0;
    hz.stallD    = 1'b0;
    hz.stallE    = 1'b0;
    hz.stallM    = 1'b0;
    hz.stallW    = 1'b0;
    hz.flushD    = 1'b0;
    hz.flushE    = 1'b0;
    hz.flushM    = 1'b0;
    hz.flushW    = 1'b0;
    hz.forwardAD = 1'b0;
    hz.forwardBD = 1'b0;
    hz.forwardAE = 2'b00;
    hz.forwardBE = 2'b00;
    hz.div_busy  = 1'b0;
    hz.div_doneE = 1'b0;
    hz.stall_cnt = '0;
    if (!rst) begin
      if (hz.excM) begin
        hz.flushD = 1'b1;
        hz.flushE = 1'b1;
        hz.flushM = 1'b1;
        hz.flushW = 1'b1;
      end else begin
        hz.stallF = stall_d;
        hz.stallD = stall_d;
        hz.stallE = div_st;
        hz.flushE = hz_st;
        hz.flushM = div_st;
      end
      hz.forwardAD = (hz.rsD != 5'd0) && hz.regwriteM &&
                     (hz.writeregM == hz.rsD);
      hz.forwardBD = (hz.rtD != 5'd0) && hz.regwriteM &&
                     (hz.writeregM == hz.rtD);
      hz.forwardAE = fwd_e(hz.rsE, hz.regwriteM, hz.writeregM,
                           hz.regwriteW, hz.writeregW);
      hz.forwardBE = fwd_e(hz.rtE, hz.regwriteM, hz.writeregM,
                           hz.regwriteW, hz.writeregW);
      hz.div_busy  = (state == DIV);
      hz.div_doneE = (state == DONE);
      hz.stall_cnt = scnt;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed test-plan steps then random
// traffic against a cycle-offset reference model.
module tb_hazard_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_if hz ();
  hazard_ctrl #(.DIV_CYCLES(N)) dut (
    .clk(clk),
    .rst(rst),
    .hz(hz)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int          cyc = 0;
  int          t0 = 0;
  bit          active = 0;
  bit          rst_seen = 0;
  bit          starting;
  logic [31:0] scnt = 0;
  logic [4:0]  e_st;
  logic [3:0]  e_fl;
  logic [5:0]  e_fw;
  logic [1:0]  e_dv;
  logic [31:0] e_cnt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit hitb(input logic [4:0] s);
    return s != 0 &&
      ((hz.regwriteE && hz.writeregE == s) ||
       (hz.memtoregM && hz.writeregM == s));
  endfunction

  function automatic logic [1:0] fe(input logic [4:0] s);
    if (s == 0) return 2'd0;
    if (hz.regwriteM && hz.writeregM == s) return 2'd2;
    if (hz.regwriteW && hz.writeregW == s) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic fd(input logic [4:0] s);
    return s != 0 && hz.regwriteM && hz.writeregM == s;
  endfunction

  // Divide tracked as cycle offset from the cycle divE was accepted
  task automatic model_eval();
    int off;
    bit busy, done, dst, haz;
    off  = active ? cyc - t0 : -1;
    busy = active && off >= 1 && off <= N - 1;
    done = active && off == N;
    starting = !active && hz.divE && !hz.excM;
    dst = starting || busy;
    haz = !busy &&
      ((hz.memtoregE && hz.rtE != 0 &&
        (hz.rtE == hz.rsD || hz.rtE == hz.rtD)) ||
       (hz.branchD && (hitb(hz.rsD) || hitb(hz.rtD))));
    if (hz.excM) begin
      e_st = 5'b0;
      e_fl = 4'b1111;
    end else begin
      e_st = {dst | haz, dst | haz, dst, 2'b00};
      e_fl = {1'b0, haz, dst, 1'b0};
    end
    e_fw  = {fd(hz.rsD), fd(hz.rtD), fe(hz.rsE), fe(hz.rtE)};
    e_dv  = {busy, done};
    e_cnt = scnt;
    if (rst && rst_seen) begin
      e_st = 0; e_fl = 0; e_fw = 0; e_dv = 0; e_cnt = 0;
    end
  endtask

  task automatic model_update();
    if (rst) begin
      active = 0;
      scnt   = 0;
    end else begin
      if (e_st[3]) scnt = scnt + 1;
      if (hz.excM) active = 0;
      else if (starting) begin
        active = 1;
        t0     = cyc;
      end else if (active && cyc - t0 == N) active = 0;
    end
    rst_seen = rst;
    cyc++;
  endtask

  task automatic cycle();
    #1;
    model_eval();
    if (!(rst && !rst_seen)) begin
      chk("stall", {hz.stallF, hz.stallD, hz.stallE,
                    hz.stallM, hz.stallW}, e_st);
      chk("flush", {hz.flushD, hz.flushE, hz.flushM,
                    hz.flushW}, e_fl);
      chk("fwd", {hz.forwardAD, hz.forwardBD,
                  hz.forwardAE, hz.forwardBE}, e_fw);
      chk("div", {hz.div_busy, hz.div_doneE}, e_dv);
      chk("stall_cnt", hz.stall_cnt, e_cnt);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clr();
    hz.rsD = 0; hz.rtD = 0; hz.rsE = 0; hz.rtE = 0;
    hz.writeregE = 0; hz.writeregM = 0; hz.writeregW = 0;
    hz.regwriteE = 0; hz.regwriteM = 0; hz.regwriteW = 0;
    hz.memtoregE = 0; hz.memtoregM = 0;
    hz.branchD = 0; hz.divE = 0; hz.excM = 0;
  endtask

  initial begin
    int nst, nbusy, donek;
    logic [31:0] s0;
    clr();
    rst = 1;
    #1;
    cycle();
    cycle();
    chk("rst_cnt", hz.stall_cnt, 0);
    chk("rst_busy", hz.div_busy, 0);
    rst = 0;
    cycle();

    // load-use
    hz.memtoregE = 1; hz.rtE = 8; hz.rsD = 8;
    s0 = hz.stall_cnt;
    #1;
    chk("lu_stall", {hz.stallF, hz.stallD, hz.flushE}, 3'b111);
    cycle();
    chk("lu_cnt", hz.stall_cnt, s0 + 1);
    hz.rtE = 0; hz.rsD = 0;
    #1;
    chk("lu_r0", hz.stallD, 0);
    cycle();

    // forwarding priority
    clr();
    hz.rsE = 5; hz.regwriteM = 1; hz.regwriteW = 1;
    hz.writeregM = 5; hz.writeregW = 5;
    #1;
    chk("fwd_m", hz.forwardAE, 2'b10);
    cycle();
    hz.regwriteM = 0;
    #1;
    chk("fwd_w", hz.forwardAE, 2'b01);
    cycle();
    hz.rsE = 0;
    #1;
    chk("fwd_r0", hz.forwardAE, 2'b00);
    cycle();

    // divide, held in E until done
    clr();
    hz.divE = 1;
    s0 = hz.stall_cnt;
    nst = 0; nbusy = 0; donek = -1;
    for (int k = 0; k < 8; k++) begin
      if (k == 5) hz.divE = 0;
      #1;
      nst   += int'(hz.stallE);
      nbusy += int'(hz.div_busy);
      if (hz.div_doneE) donek = k;
      cycle();
    end
    chk("div_stallE", nst, 4);
    chk("div_busy_n", nbusy, 3);
    chk("div_done_at", donek, 4);
    chk("div_cnt", hz.stall_cnt - s0, 4);

    // exception abort on second DIV cycle
    clr();
    hz.divE = 1;
    cycle();
    cycle();
    hz.excM = 1;
    #1;
    chk("exc_flush", {hz.flushD, hz.flushE, hz.flushM,
                      hz.flushW}, 4'hf);
    chk("exc_stall", {hz.stallF, hz.stallD, hz.stallE}, 0);
    cycle();
    hz.excM = 0; hz.divE = 0;
    #1;
    chk("exc_idle", hz.div_busy, 0);
    cycle();

    // branch hazard then forward from M
    clr();
    hz.branchD = 1; hz.rsD = 3; hz.regwriteE = 1; hz.writeregE = 3;
    #1;
    chk("br_stall", {hz.stallD, hz.flushE}, 2'b11);
    cycle();
    hz.regwriteE = 0; hz.regwriteM = 1; hz.writeregM = 3;
    #1;
    chk("br_fwd", {hz.stallD, hz.forwardAD}, 2'b01);
    cycle();

    // sync reset mid-divide
    clr();
    hz.divE = 1;
    cycle();
    cycle();
    rst = 1;
    cycle();
    chk("rst_div_busy", hz.div_busy, 0);
    chk("rst_div_cnt", hz.stall_cnt, 0);
    chk("rst_div_st", hz.stallD, 0);
    cycle();
    rst = 0; hz.divE = 0;
    cycle();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      hz.rsD = 5'($urandom_range(0, 3));
      hz.rtD = 5'($urandom_range(0, 3));
      hz.rsE = 5'($urandom_range(0, 3));
      hz.rtE = 5'($urandom_range(0, 3));
      hz.writeregE = 5'($urandom_range(0, 3));
      hz.writeregM = 5'($urandom_range(0, 3));
      hz.writeregW = 5'($urandom_range(0, 3));
      hz.regwriteE = 1'($urandom_range(0, 1));
      hz.regwriteM = 1'($urandom_range(0, 1));
      hz.regwriteW = 1'($urandom_range(0, 1));
      hz.memtoregE = 1'($urandom_range(0, 1));
      hz.memtoregM = 1'($urandom_range(0, 1));
      hz.branchD = 1'($urandom_range(0, 1));
      hz.divE = ($urandom_range(0, 5) == 0);
      hz.excM = ($urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
